// File: rtl/fc_mem_pkg.sv
// Shared types and widths for the FC memory responder.
// Word-port address/data widths and the responder FSM states.
package fc_mem_pkg;
  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_e;
endpackage

// File: rtl/fc_sram_sp.sv
// Single-port synchronous SRAM, one-cycle registered read.
// Read and write are never requested in the same cycle.
module fc_sram_sp #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/fc_mem_responder.sv
// FC loader word-port responder: fixed-latency reads and writes
// served from a single-port SRAM, with a sticky out-of-range flag.
module fc_mem_responder
  import fc_mem_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rvalid,
  input  logic [ADDR_W-1:0] raddr,
  output logic              rready,
  output logic [DATA_W-1:0] rdata,
  input  logic              wvalid,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic              wready,
  output logic              err
);
  localparam int AW   = $clog2(DEPTH);
  localparam int LMAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CW   = $clog2(LMAX + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rready_q, rready_d;
  logic              wready_q, wready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              oob_q, oob_d;

  logic              r_oob, w_oob;
  logic              sram_we, sram_re;
  logic [AW-1:0]     sram_addr;
  logic [DATA_W-1:0] sram_rdata;

  assign r_oob = |raddr[ADDR_W-1:AW];
  assign w_oob = |waddr[ADDR_W-1:AW];

  fc_sram_sp #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DATA_W)
  ) u_sram (
    .clk    (clk),
    .we_i   (sram_we),
    .re_i   (sram_re),
    .addr_i (sram_addr),
    .wdata_i(wdata),
    .rdata_o(sram_rdata)
  );

  // Counter holds cycles elapsed since acceptance; the
  // pulse lands in cycle accept+LAT, so RESP follows LAT-1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rready_d  = 1'b0;
    wready_d  = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    oob_d     = oob_q;
    sram_we   = 1'b0;
    sram_re   = 1'b0;
    sram_addr = wvalid ? waddr[AW-1:0] : raddr[AW-1:0];
    unique case (state_q)
      IDLE: begin
        if (wvalid) begin
          err_d   = err_q | w_oob;
          sram_we = ~w_oob;
          if (WR_LAT == 1) begin
            state_d  = RESP;
            wready_d = 1'b1;
          end else begin
            state_d = WR;
            cnt_d   = CW'(1);
          end
        end else if (rvalid) begin
          err_d   = err_q | r_oob;
          oob_d   = r_oob;
          sram_re = ~r_oob;
          state_d = RD;
          cnt_d   = CW'(1);
        end
      end
      RD: begin
        if (cnt_q == CW'(RD_LAT - 1)) begin
          state_d  = RESP;
          rready_d = 1'b1;
          rdata_d  = oob_q ? '0 : sram_rdata;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WR: begin
        if (cnt_q == CW'(WR_LAT - 1)) begin
          state_d  = RESP;
          wready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rready_q <= 1'b0;
      wready_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rready_q <= rready_d;
      wready_q <= wready_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      oob_q    <= oob_d;
    end
  end

  assign rready = rready_q;
  assign wready = wready_q;
  assign rdata  = rdata_q;
  assign err    = err_q;
endmodule

// File: tb/tb_fc_mem_responder.sv
// Directed bench for fc_mem_responder: default build (a) and a
// long-latency build (b, RD_LAT=5, WR_LAT=3) sharing clk/rst.
module tb_fc_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        rvalid_a = 0, wvalid_a = 0;
  logic [25:0] raddr_a = 0, waddr_a = 0;
  logic [31:0] wdata_a = 0;
  logic        rready_a, wready_a, err_a;
  logic [31:0] rdata_a;

  logic        rvalid_b = 0, wvalid_b = 0;
  logic [25:0] raddr_b = 0, waddr_b = 0;
  logic [31:0] wdata_b = 0;
  logic        rready_b, wready_b, err_b;
  logic [31:0] rdata_b;

  int tests = 0;
  int fails = 0;
  int n;

  always #5 clk = ~clk;

  fc_mem_responder u_a (
    .clk(clk), .rst(rst),
    .rvalid(rvalid_a), .raddr(raddr_a),
    .rready(rready_a), .rdata(rdata_a),
    .wvalid(wvalid_a), .waddr(waddr_a),
    .wdata(wdata_a), .wready(wready_a),
    .err(err_a)
  );

  fc_mem_responder #(.RD_LAT(5), .WR_LAT(3)) u_b (
    .clk(clk), .rst(rst),
    .rvalid(rvalid_b), .raddr(raddr_b),
    .rready(rready_b), .rdata(rdata_b),
    .wvalid(wvalid_b), .waddr(waddr_b),
    .wdata(wdata_b), .wready(wready_b),
    .err(err_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic pulse(bit b, bit w);
    if (b) return w ? wready_b : rready_b;
    return w ? wready_a : rready_a;
  endfunction

  // Bounded wait; a timeout shows up as a latency mismatch.
  task automatic wait_pulse(bit b, bit w, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!pulse(b, w) && cnt < 40);
  endtask

  task automatic do_write(bit b, logic [25:0] a,
                          logic [31:0] d, int lat, string tag);
    int k;
    if (b) begin
      wvalid_b = 1; waddr_b = a; wdata_b = d;
    end else begin
      wvalid_a = 1; waddr_a = a; wdata_a = d;
    end
    wait_pulse(b, 1'b1, k);
    chk({tag, ".wlat"}, k, lat);
    if (b) wvalid_b = 0; else wvalid_a = 0;
    tick();
    chk({tag, ".wwidth"}, {31'b0, pulse(b, 1'b1)}, 0);
  endtask

  task automatic do_read(bit b, logic [25:0] a,
                         logic [31:0] exp, int lat, string tag);
    int k;
    if (b) begin
      rvalid_b = 1; raddr_b = a;
    end else begin
      rvalid_a = 1; raddr_a = a;
    end
    wait_pulse(b, 1'b0, k);
    chk({tag, ".rlat"}, k, lat);
    chk({tag, ".rdata"}, b ? rdata_b : rdata_a, exp);
    if (b) rvalid_b = 0; else rvalid_a = 0;
    tick();
    chk({tag, ".rwidth"}, {31'b0, pulse(b, 1'b0)}, 0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst.rready", {31'b0, rready_a}, 0);
    chk("rst.wready", {31'b0, wready_a}, 0);
    chk("rst.rdata", rdata_a, 0);
    chk("rst.err", {31'b0, err_a}, 0);
    rst = 0;
    tick();

    // basic write then read
    do_write(0, 26'h010, 32'hDEADBEEF, 1, "t1");
    do_read(0, 26'h010, 32'hDEADBEEF, 2, "t1");

    // loader-style stream, address advanced after each pulse
    for (int i = 0; i < 4; i++)
      do_write(0, 26'h100 + 26'(i), 32'(i + 1), 1, "pre");
    rvalid_a = 1;
    raddr_a  = 26'h100;
    for (int i = 0; i < 4; i++) begin
      wait_pulse(0, 1'b0, n);
      chk("strm.lat", n, (i == 0) ? 2 : 3);
      chk("strm.data", rdata_a, 32'(i + 1));
      if (i < 3) raddr_a = 26'h101 + 26'(i);
      else rvalid_a = 0;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("strm.nodup", {31'b0, rready_a}, 0);
    end

    // simultaneous read/write: write served first
    do_write(0, 26'h020, 32'h11, 1, "t3pre");
    rvalid_a = 1; raddr_a = 26'h020;
    wvalid_a = 1; waddr_a = 26'h020; wdata_a = 32'h55;
    wait_pulse(0, 1'b1, n);
    chk("t3.wlat", n, 1);
    chk("t3.rquiet", {31'b0, rready_a}, 0);
    wvalid_a = 0;
    wait_pulse(0, 1'b0, n);
    chk("t3.rlat", n, 3);
    chk("t3.rdata", rdata_a, 32'h55);
    rvalid_a = 0;
    tick();

    // out-of-range: zero data, sticky err, write dropped
    do_read(0, 26'h2000000, 32'h0, 2, "t4");
    chk("t4.err", {31'b0, err_a}, 1);
    do_write(0, 26'h2000010, 32'hBAD0BAD0, 1, "t4w");
    do_read(0, 26'h010, 32'hDEADBEEF, 2, "t4alias");
    chk("t4.errstk", {31'b0, err_a}, 1);

    // reset one cycle after read acceptance
    rvalid_a = 1; raddr_a = 26'h010;
    tick();
    rst = 1; rvalid_a = 0;
    tick();
    chk("t5.rready", {31'b0, rready_a}, 0);
    chk("t5.rdata", rdata_a, 0);
    chk("t5.err", {31'b0, err_a}, 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5.nopulse", {31'b0, rready_a}, 0);
    end
    do_read(0, 26'h101, 32'h2, 2, "t5post");

    // long-latency build
    do_write(1, 26'h033, 32'hCAFEF00D, 3, "t6");
    do_read(1, 26'h033, 32'hCAFEF00D, 5, "t6");
    chk("t6.err", {31'b0, err_b}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
